hpdl_write_scheduler: RTL

//  Sequences writes to four HPDL-1414 devices (16 places) sharing one 7-bit data bus,
//  2-bit address bus and per-device active-low WR strobes. Keeps a 16-char shadow

---
 rtl/hpdl_write_scheduler_if.sv | 25 ++
 rtl/hpdl_write_scheduler.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/hpdl_write_scheduler_if.sv
// Bundle between the character/caret logic and the HPDL-1414 write scheduler.
// master: host side (char writer + caret control), observes busy and display pins.
// slave:  scheduler side, accepts writes and drives the shared display bus.
interface hpdl_write_scheduler_if;
  logic       wr_valid;   // host write request
  logic       wr_ready;   // write accepted when wr_valid & wr_ready
  logic [3:0] wr_pos;     // place 0..15, [3:2] device, [1:0] digit
  logic [6:0] wr_char;    // ASCII code
  logic       caret_en;   // caret overlay enable
  logic [3:0] caret_pos;  // caret place
  logic       busy;       // any place dirty or bus cycle running
  logic [6:0] hpdl_d;     // display data bus
  logic [1:0] hpdl_a;     // display digit address (~pos[1:0])
  logic [3:0] hpdl_wr_n;  // per-device active-low write strobes

  modport master (
    output wr_valid, wr_pos, wr_char, caret_en, caret_pos,
    input  wr_ready, busy, hpdl_d, hpdl_a, hpdl_wr_n
  );

  modport slave (
    input  wr_valid, wr_pos, wr_char, caret_en, caret_pos,
    output wr_ready, busy, hpdl_d, hpdl_a, hpdl_wr_n
  );
endinterface

// File: rtl/hpdl_write_scheduler.sv
// Write scheduler for four HPDL-1414 devices (16 places) on one shared bus.
// Ports: clk, rst (sync, active high); bus (slave modport): host write handshake,
// caret control, busy flag and the HPDL data/address/WR pins.
// A shadow buffer with per-place dirty bits drives round-robin rewrites of
// changed places; each bus cycle is IDLE(1) + SETUP + STROBE + HOLD cycles.
module hpdl_write_scheduler #(
  parameter int         T_SETUP   = 2,
  parameter int         T_WR      = 3,
  parameter int         T_HOLD    = 2,
  parameter int         BLINK_BIT = 22,
  parameter logic [6:0] CARET_CHR = 7'h5F
) (
  input  logic clk,
  input  logic rst,
  hpdl_write_scheduler_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t       state, state_nxt;
  logic [7:0]   tcnt, tcnt_nxt;
  logic [6:0]   shadow [16];
  logic [15:0]  dirty, dirty_nxt, set_vec, clr_vec;
  logic [3:0]   ptr, ptr_nxt, cur, cur_nxt;
  logic [6:0]   d_q, d_nxt;
  logic [1:0]   a_q, a_nxt;
  logic [BLINK_BIT:0] blink_cnt;
  logic         phase_q, phase, phase_toggle;
  logic [3:0]   caret_pos_q;
  logic         caret_en_q;
  logic [3:0]   pick, idx;
  logic         pick_vld;
  logic [6:0]   glyph;
  logic         accept;

  assign bus.wr_ready = ~rst;
  assign accept       = bus.wr_valid & bus.wr_ready;
  assign phase        = blink_cnt[BLINK_BIT];
  // Registered copy of the phase lags by one cycle, so a mismatch marks a toggle.
  assign phase_toggle = phase ^ phase_q;

  // First dirty place at or after ptr: scan downward so the lowest offset wins.
  always_comb begin
    pick     = ptr;
    pick_vld = 1'b0;
    idx      = '0;
    for (int i = 15; i >= 0; i--) begin
      idx = ptr + 4'(i);
      if (dirty[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

  assign glyph = (bus.caret_en && pick == bus.caret_pos && !phase) ? CARET_CHR : shadow[pick];

  // Dirty sources: host writes, caret blink, and restoring the place the caret left.
  always_comb begin
    set_vec = '0;
    if (accept) set_vec[bus.wr_pos] = 1'b1;
    if (phase_toggle && bus.caret_en) set_vec[bus.caret_pos] = 1'b1;
    if (caret_en_q && (!bus.caret_en || bus.caret_pos != caret_pos_q))
      set_vec[caret_pos_q] = 1'b1;
  end

  // Set is applied after clear so a write landing on the latch edge is not lost.
  assign dirty_nxt = (dirty & ~clr_vec) | set_vec;

  always_comb begin
    state_nxt = state;
    tcnt_nxt  = tcnt;
    ptr_nxt   = ptr;
    cur_nxt   = cur;
    d_nxt     = d_q;
    a_nxt     = a_q;
    clr_vec   = '0;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          cur_nxt       = pick;
          d_nxt         = glyph;
          a_nxt         = ~pick[1:0];
          clr_vec[pick] = 1'b1;
          tcnt_nxt      = '0;
          state_nxt     = SETUP;
        end
      end
      SETUP: begin
        if (tcnt == 8'(T_SETUP - 1)) begin
          tcnt_nxt  = '0;
          state_nxt = STROBE;
        end else begin
          tcnt_nxt = tcnt + 8'd1;
        end
      end
      STROBE: begin
        if (tcnt == 8'(T_WR - 1)) begin
          tcnt_nxt  = '0;
          state_nxt = HOLD;
        end else begin
          tcnt_nxt = tcnt + 8'd1;
        end
      end
      HOLD: begin
        if (tcnt == 8'(T_HOLD - 1)) begin
          tcnt_nxt  = '0;
          ptr_nxt   = cur + 4'd1;
          state_nxt = IDLE;
        end else begin
          tcnt_nxt = tcnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      tcnt        <= '0;
      dirty       <= 16'hFFFF;
      ptr         <= '0;
      cur         <= '0;
      d_q         <= 7'h20;
      a_q         <= 2'b11;
      blink_cnt   <= '0;
      phase_q     <= 1'b0;
      caret_pos_q <= '0;
      caret_en_q  <= 1'b0;
      for (int i = 0; i < 16; i++) shadow[i] <= 7'h20;
    end else begin
      state       <= state_nxt;
      tcnt        <= tcnt_nxt;
      dirty       <= dirty_nxt;
      ptr         <= ptr_nxt;
      cur         <= cur_nxt;
      d_q         <= d_nxt;
      a_q         <= a_nxt;
      blink_cnt   <= blink_cnt + {{BLINK_BIT{1'b0}}, 1'b1};
      phase_q     <= phase;
      caret_pos_q <= bus.caret_pos;
      caret_en_q  <= bus.caret_en;
      if (accept) shadow[bus.wr_pos] <= bus.wr_char;
    end
  end

  assign bus.hpdl_d    = d_q;
  assign bus.hpdl_a    = a_q;
  // Decoded from registers only; a single device strobe is low in STROBE.
  assign bus.hpdl_wr_n = (state == STROBE) ? ~(4'b0001 << cur[3:2]) : 4'hF;
  assign bus.busy      = (state != IDLE) | (|dirty);

endmodule
